// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round sequencer: random wait, timed GO window, result hold.
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   start        start a round (honoured in IDLE and DONE only)
//   button       synchronised player button, active-high level
//   led_go       high while the GO window is open
//   busy         high during WAIT or GO
//   wait_ms      random wait target of the current/last round
//   result_ms    measured reaction time in ms
//   result_valid one-cycle pulse on DONE entry
//   false_start  last round ended by a press during WAIT
//   timeout      last round ended with no press in the GO window
module reaction_round_ctrl #(
    parameter int CLKS_PER_MS = 50000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int WAIT_BITS   = 12,
    parameter int TIMEOUT_MS  = 2000,
    localparam int WW = $clog2(MIN_WAIT_MS + 2**WAIT_BITS),
    localparam int RW = $clog2(TIMEOUT_MS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          button,
    output logic          led_go,
    output logic          busy,
    output logic [WW-1:0] wait_ms,
    output logic [RW-1:0] result_ms,
    output logic          result_valid,
    output logic          false_start,
    output logic          timeout
);

    localparam int CW = (WW > RW) ? WW : RW;
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam logic [PW-1:0] PS_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_MS - 1);
    localparam logic [RW-1:0] TO_VAL  = RW'(TIMEOUT_MS);
    localparam logic [WW-1:0] MIN_W   = WW'(MIN_WAIT_MS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic [CW-1:0]   ms_q, ms_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [RW-1:0]   res_q, res_d;
    logic            fs_q, fs_d;
    logic            to_q, to_d;
    logic            rv_q, rv_d;
    logic [11:0]     lfsr_q, lfsr_d;
    logic            button_q;

    logic            ms_tick;
    logic            press;
    logic [CW-1:0]   ms_inc;
    logic            lfsr_fb;

    assign ms_tick = (ps_q == PS_LAST);
    assign press   = button & ~button_q;
    assign ms_inc  = ms_q + CW'(1);
    assign lfsr_fb = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        ms_d    = ms_q;
        wait_d  = wait_q;
        res_d   = res_q;
        fs_d    = fs_q;
        to_d    = to_q;
        rv_d    = 1'b0;
        lfsr_d  = {lfsr_q[10:0], lfsr_fb};

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    wait_d  = MIN_W + WW'(lfsr_q[WAIT_BITS-1:0]);
                    fs_d    = 1'b0;
                    to_d    = 1'b0;
                    res_d   = '0;
                end
            end
            S_WAIT: begin
                // press wins over a coincident ms_tick
                if (press) begin
                    state_d = S_DONE;
                    fs_d    = 1'b1;
                    res_d   = '0;
                    rv_d    = 1'b1;
                end else if (ms_tick) begin
                    // compare ms_cnt+1 to avoid wait_ms-1 underflow
                    if (ms_inc == CW'(wait_q)) begin
                        state_d = S_GO;
                    end else begin
                        ms_d = ms_inc;
                    end
                end
            end
            S_GO: begin
                if (press) begin
                    state_d = S_DONE;
                    res_d   = RW'(ms_q);
                    rv_d    = 1'b1;
                end else if (ms_tick) begin
                    if (ms_q == TO_LAST) begin
                        state_d = S_DONE;
                        to_d    = 1'b1;
                        res_d   = TO_VAL;
                        rv_d    = 1'b1;
                    end else begin
                        ms_d = ms_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // timebase only runs in WAIT/GO and restarts on every transition
        if ((state_d != state_q) ||
            !((state_q == S_WAIT) || (state_q == S_GO))) begin
            ps_d = '0;
            ms_d = '0;
        end else if (ms_tick) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ps_q     <= '0;
            ms_q     <= '0;
            wait_q   <= '0;
            res_q    <= '0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
            rv_q     <= 1'b0;
            lfsr_q   <= 12'hACE;
            button_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            ms_q     <= ms_d;
            wait_q   <= wait_d;
            res_q    <= res_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
            rv_q     <= rv_d;
            lfsr_q   <= lfsr_d;
            button_q <= button;
        end
    end

    assign led_go       = (state_q == S_GO);
    assign busy         = (state_q == S_WAIT) || (state_q == S_GO);
    assign wait_ms      = wait_q;
    assign result_ms    = res_q;
    assign result_valid = rv_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;

endmodule
